// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and helpers for the register bank and its debug dump engine.
//   dump_state_e : dump FSM states (IDLE / LOAD / SEND)
//   read_bypass  : read value of one register with write-first bypass and
//                  the optional hard-wired zero register applied
// -----------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } dump_state_e;

    // The helper works on fixed 32-bit operands so one function serves every
    // BITS/ABITS instance; callers widen the inputs and truncate the result.
    localparam int MAX_W = 32;

    // A write to the read address in the same cycle wins over the stored
    // value. A dropped write to register 0 never shows up, because the zero
    // rule is tested first.
    function automatic logic [MAX_W-1:0] read_bypass(
        input logic [MAX_W-1:0] stored,
        input logic [MAX_W-1:0] addr,
        input logic [MAX_W-1:0] waddr,
        input logic             wenable,
        input logic [MAX_W-1:0] wdata,
        input logic             zero_reg
    );
        if (zero_reg && addr == '0)
            return '0;
        if (wenable && waddr == addr)
            return wdata;
        return stored;
    endfunction

endpackage

// File: rtl/regfile_rd_if.sv
// -----------------------------------------------------------------------------
// regfile_rd_if
// Bus bundle between the register bank and its users.
//   write port : wenable, waddr, wdata
//   read ports : raddr0/rdata0, raddr1/rdata1 (data registered, latency 1)
//   dump port  : dump_start, dump_busy, dump_valid/dump_ready handshake,
//                dump_addr, dump_data
// master = user side (decode / debug logic), slave = register bank.
// -----------------------------------------------------------------------------
interface regfile_rd_if #(
    parameter int BITS  = 4,
    parameter int NREGS = 8
);
    localparam int ABITS = $clog2(NREGS);

    logic             wenable;
    logic [ABITS-1:0] waddr;
    logic [BITS-1:0]  wdata;
    logic [ABITS-1:0] raddr0;
    logic [BITS-1:0]  rdata0;
    logic [ABITS-1:0] raddr1;
    logic [BITS-1:0]  rdata1;
    logic             dump_start;
    logic             dump_busy;
    logic             dump_valid;
    logic             dump_ready;
    logic [ABITS-1:0] dump_addr;
    logic [BITS-1:0]  dump_data;

    modport master (
        output wenable, waddr, wdata, raddr0, raddr1, dump_start, dump_ready,
        input  rdata0, rdata1, dump_busy, dump_valid, dump_addr, dump_data
    );

    modport slave (
        input  wenable, waddr, wdata, raddr0, raddr1, dump_start, dump_ready,
        output rdata0, rdata1, dump_busy, dump_valid, dump_addr, dump_data
    );

endinterface

// File: rtl/regfile_dump_fsm.sv
// -----------------------------------------------------------------------------
// regfile_dump_fsm
// Walks every register index once and presents each as one valid/ready beat.
// A beat is captured in LOAD (one cycle) and held in SEND until accepted, so
// the presented data is a snapshot that later writes do not disturb.
//   clk, rst   : clock, synchronous active-high reset
//   i_start    : begin a dump (ignored while busy)
//   i_ready    : consumer accepts the current beat
//   o_rd_addr  : index fed to the bank's bypassed read path
//   i_rd_data  : bypassed register value for o_rd_addr
//   o_busy     : dump in progress
//   o_valid    : o_addr / o_data form a valid beat
//   o_addr     : index of the presented register
//   o_data     : snapshot of that register
// -----------------------------------------------------------------------------
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int BITS  = 4,
    parameter int NREGS = 8,
    parameter int ABITS = $clog2(NREGS)   // derived; do not override
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_ready,
    output logic [ABITS-1:0] o_rd_addr,
    input  logic [BITS-1:0]  i_rd_data,
    output logic             o_busy,
    output logic             o_valid,
    output logic [ABITS-1:0] o_addr,
    output logic [BITS-1:0]  o_data
);

    localparam logic [ABITS-1:0] LAST_IDX = ABITS'(NREGS - 1);

    dump_state_e      r_state;
    dump_state_e      w_state_nxt;
    logic [ABITS-1:0] r_idx;
    logic [ABITS-1:0] w_idx_nxt;
    logic             w_load;
    logic [ABITS-1:0] r_addr;
    logic [BITS-1:0]  r_data;

    // NOTE: every output of always_comb is given a default before the case
    // statement, so no path leaves a signal unassigned and no latch appears.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        o_busy      = 1'b1;
        o_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_nxt = LOAD;
                    w_idx_nxt   = '0;
                end
            end
            LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = SEND;
            end
            SEND: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + ABITS'(1);
                        w_state_nxt = LOAD;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_load) begin
                r_addr <= r_idx;
                r_data <= i_rd_data;
            end
        end
    end

    assign o_rd_addr = r_idx;
    assign o_addr    = r_addr;
    assign o_data    = r_data;

endmodule

// File: rtl/regfile_rd.sv
// -----------------------------------------------------------------------------
// regfile_rd
// Register bank with one write port, two registered read ports (write-first
// bypass) and a serial debug dump port.
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset, clears storage, read data and dump
//   bus  : regfile_rd_if slave modport (write, read and dump signals)
// Parameters: BITS data width, NREGS register count (power of two, >= 2),
// ZERO_REG = 1 makes register 0 read as zero and drops writes to it.
// -----------------------------------------------------------------------------
module regfile_rd
    import regfile_pkg::*;
#(
    parameter int BITS     = 4,
    parameter int NREGS    = 8,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_rd_if.slave  bus
);

    localparam int   ABITS  = $clog2(NREGS);
    localparam logic W_ZERO = (ZERO_REG != 0);

    logic [BITS-1:0]  r_regs [NREGS];
    logic [BITS-1:0]  r_rdata0;
    logic [BITS-1:0]  r_rdata1;
    logic             w_wr_en;
    logic [BITS-1:0]  w_rd0;
    logic [BITS-1:0]  w_rd1;
    logic [ABITS-1:0] w_dump_raddr;
    logic [BITS-1:0]  w_dump_rdata;

    assign w_wr_en = bus.wenable && !(W_ZERO && bus.waddr == '0);

    // Three bypassed read paths share one rule: both read ports and the dump
    // snapshot see a same-cycle write exactly as a later read would.
    assign w_rd0 = BITS'(read_bypass(MAX_W'(r_regs[bus.raddr0]), MAX_W'(bus.raddr0),
                                     MAX_W'(bus.waddr), bus.wenable,
                                     MAX_W'(bus.wdata), W_ZERO));
    assign w_rd1 = BITS'(read_bypass(MAX_W'(r_regs[bus.raddr1]), MAX_W'(bus.raddr1),
                                     MAX_W'(bus.waddr), bus.wenable,
                                     MAX_W'(bus.wdata), W_ZERO));
    assign w_dump_rdata = BITS'(read_bypass(MAX_W'(r_regs[w_dump_raddr]),
                                            MAX_W'(w_dump_raddr),
                                            MAX_W'(bus.waddr), bus.wenable,
                                            MAX_W'(bus.wdata), W_ZERO));

    // NOTE: the storage array is reset explicitly because cleared registers
    // are architecturally visible; this keeps it in flops rather than RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[bus.waddr] <= bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_rdata0 <= w_rd0;
            r_rdata1 <= w_rd1;
        end
    end

    assign bus.rdata0 = r_rdata0;
    assign bus.rdata1 = r_rdata1;

    regfile_dump_fsm #(
        .BITS  (BITS),
        .NREGS (NREGS),
        .ABITS (ABITS)
    ) u_dump (
        .clk       (clk),
        .rst       (rst),
        .i_start   (bus.dump_start),
        .i_ready   (bus.dump_ready),
        .o_rd_addr (w_dump_raddr),
        .i_rd_data (w_dump_rdata),
        .o_busy    (bus.dump_busy),
        .o_valid   (bus.dump_valid),
        .o_addr    (bus.dump_addr),
        .o_data    (bus.dump_data)
    );

endmodule

// File: tb/tb_regfile_rd.sv
// -----------------------------------------------------------------------------
// tb_regfile_rd
// Self-checking bench for regfile_rd. A behavioural model tracks register
// contents (reads see the post-write contents, register 0 stays zero) and the
// dump as a stream of beats: each beat's data is the register content at the
// edge where the beat becomes valid, and stays put until accepted.
// -----------------------------------------------------------------------------
module tb_regfile_rd;

    localparam int BITS  = 4;
    localparam int NREGS = 8;
    localparam int ABITS = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_rd_if #(.BITS(BITS), .NREGS(NREGS)) bus ();

    regfile_rd #(
        .BITS     (BITS),
        .NREGS    (NREGS),
        .ZERO_REG (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference model state
    logic [BITS-1:0]  model [NREGS];
    logic [BITS-1:0]  exp_rd0, exp_rd1;
    logic [BITS-1:0]  held_data;
    logic [ABITS-1:0] held_addr;
    logic             exp_busy, exp_valid, load_pending;
    int               beat_idx;
    int               beats_accepted;
    int               n_cmp, n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: capture the inputs the edge will see, advance the model,
    // then compare all outputs 1 time unit after the edge.
    task automatic tick();
        logic             we, st, rdy, rs, obs_hs, hs, new_valid, new_load;
        logic [ABITS-1:0] wa, a0, a1;
        logic [BITS-1:0]  wd;
        we     = bus.wenable;
        wa     = bus.waddr;
        wd     = bus.wdata;
        a0     = bus.raddr0;
        a1     = bus.raddr1;
        st     = bus.dump_start;
        rdy    = bus.dump_ready;
        rs     = rst;
        obs_hs = bus.dump_valid && bus.dump_ready;
        @(posedge clk);
        if (obs_hs && !rs)
            beats_accepted++;
        if (rs) begin
            for (int i = 0; i < NREGS; i++)
                model[i] = '0;
            exp_rd0      = '0;
            exp_rd1      = '0;
            exp_busy     = 1'b0;
            exp_valid    = 1'b0;
            load_pending = 1'b0;
            beat_idx     = 0;
            held_addr    = '0;
            held_data    = '0;
        end else begin
            if (we && wa != '0)
                model[wa] = wd;
            exp_rd0 = model[a0];
            exp_rd1 = model[a1];
            hs = exp_valid && rdy;
            if (load_pending) begin
                held_addr = ABITS'(beat_idx);
                held_data = model[beat_idx];
            end
            new_valid = load_pending || (exp_valid && !hs);
            new_load  = (!exp_busy && st) || (hs && beat_idx != NREGS - 1);
            if (!exp_busy && st) begin
                exp_busy = 1'b1;
                beat_idx = 0;
            end else if (hs) begin
                if (beat_idx == NREGS - 1) begin
                    exp_busy = 1'b0;
                    beat_idx = 0;
                end else begin
                    beat_idx++;
                end
            end
            exp_valid    = new_valid;
            load_pending = new_load;
        end
        #1;
        check("rdata0", 32'(bus.rdata0), 32'(exp_rd0));
        check("rdata1", 32'(bus.rdata1), 32'(exp_rd1));
        check("dump_busy", 32'(bus.dump_busy), 32'(exp_busy));
        check("dump_valid", 32'(bus.dump_valid), 32'(exp_valid));
        if (exp_valid || rs) begin
            check("dump_addr", 32'(bus.dump_addr), 32'(held_addr));
            check("dump_data", 32'(bus.dump_data), 32'(held_data));
        end
    endtask

    task automatic wait_beat(input int addr, input int budget);
        int n;
        n = 0;
        while (!(bus.dump_valid && bus.dump_addr == ABITS'(addr)) && n < budget) begin
            tick();
            n++;
        end
        check("wait_beat", 32'(bus.dump_valid && bus.dump_addr == ABITS'(addr)), 32'd1);
    endtask

    task automatic run_until_idle(input int budget, output int cycles);
        cycles = 0;
        while (bus.dump_busy && cycles < budget) begin
            tick();
            cycles++;
        end
        check("idle_reached", 32'(bus.dump_busy), 32'd0);
    endtask

    task automatic write_reg(input int addr, input int data);
        bus.wenable = 1'b1;
        bus.waddr   = ABITS'(addr);
        bus.wdata   = BITS'(data);
        tick();
        bus.wenable = 1'b0;
    endtask

    initial begin
        int cycles;
        n_cmp          = 0;
        n_err          = 0;
        beats_accepted = 0;
        bus.wenable    = 1'b0;
        bus.waddr      = '0;
        bus.wdata      = '0;
        bus.raddr0     = '0;
        bus.raddr1     = '0;
        bus.dump_start = 1'b0;
        bus.dump_ready = 1'b0;
        rst            = 1'b1;
        #2;

        // Reset then read
        tick();
        tick();
        rst        = 1'b0;
        bus.raddr0 = 3'd3;
        bus.raddr1 = 3'd5;
        tick();
        check("rst_rd0", 32'(bus.rdata0), 32'h0);
        check("rst_rd1", 32'(bus.rdata1), 32'h0);
        check("rst_busy", 32'(bus.dump_busy), 32'h0);

        // Write then read; a disabled write changes nothing
        write_reg(3, 4'b1010);
        bus.raddr0 = 3'd3;
        tick();
        check("wr_rd0", 32'(bus.rdata0), 32'b1010);
        bus.wdata = 4'b1111;
        tick();
        check("wr_hold", 32'(bus.rdata0), 32'b1010);

        // Same-cycle bypass on both ports, and register 0 stays zero
        bus.raddr0 = 3'd2;
        bus.raddr1 = 3'd2;
        write_reg(2, 4'b0110);
        check("byp_rd0", 32'(bus.rdata0), 32'b0110);
        check("byp_rd1", 32'(bus.rdata1), 32'b0110);
        bus.raddr0 = 3'd0;
        write_reg(0, 4'b1111);
        check("zero_byp", 32'(bus.rdata0), 32'h0);
        tick();
        check("zero_rd", 32'(bus.rdata0), 32'h0);

        // Full dump with ready held high
        for (int i = 1; i < NREGS; i++)
            write_reg(i, i);
        bus.dump_ready = 1'b1;
        beats_accepted = 0;
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        run_until_idle(40, cycles);
        check("full_busy_cycles", 32'(cycles), 32'(2 * NREGS));
        check("full_beats", 32'(beats_accepted), 32'(NREGS));

        // Backpressure on beat 4 while reg 4 is rewritten; mid-dump start ignored
        beats_accepted = 0;
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        wait_beat(4, 20);
        bus.dump_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.wenable    = (i == 1);
            bus.waddr      = 3'd4;
            bus.wdata      = 4'b1100;
            bus.dump_start = (i == 3);
            tick();
        end
        bus.wenable    = 1'b0;
        bus.dump_start = 1'b0;
        check("bp_addr", 32'(bus.dump_addr), 32'd4);
        check("bp_data", 32'(bus.dump_data), 32'b0100);
        bus.dump_ready = 1'b1;
        run_until_idle(40, cycles);
        check("bp_beats", 32'(beats_accepted), 32'(NREGS));
        bus.raddr0 = 3'd4;
        tick();
        check("bp_reg4", 32'(bus.rdata0), 32'b1100);

        // Reset in the middle of a dump, then restart from address 0
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        wait_beat(3, 20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(bus.dump_valid), 32'h0);
        check("mid_rst_busy", 32'(bus.dump_busy), 32'h0);
        bus.raddr0 = 3'd4;
        bus.raddr1 = 3'd7;
        tick();
        check("mid_rst_reg4", 32'(bus.rdata0), 32'h0);
        check("mid_rst_reg7", 32'(bus.rdata1), 32'h0);
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        wait_beat(0, 10);
        check("restart_addr", 32'(bus.dump_addr), 32'h0);
        run_until_idle(40, cycles);

        // Randomised traffic with occasional dumps, backpressure and resets
        for (int n = 0; n < 1500; n++) begin
            bus.wenable    = $urandom_range(0, 1) == 1;
            bus.waddr      = ABITS'($urandom);
            bus.wdata      = BITS'($urandom);
            bus.raddr0     = ABITS'($urandom);
            bus.raddr1     = ($urandom_range(0, 3) == 0) ? bus.waddr : ABITS'($urandom);
            bus.dump_start = $urandom_range(0, 15) == 0;
            bus.dump_ready = $urandom_range(0, 3) != 0;
            rst            = $urandom_range(0, 299) == 0;
            tick();
        end
        rst            = 1'b0;
        bus.wenable    = 1'b0;
        bus.dump_start = 1'b0;
        bus.dump_ready = 1'b1;
        run_until_idle(40, cycles);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_rd.md
Name: regfile_rd

Overview:
- Multi-register bank: one write port and two registered read ports, plus a serial debug dump port that streams every register out over a valid/ready handshake.
- Serves as the read side of the CPU register storage. The decode stage drives the read ports; the debug/trace logic drives the dump port.
- Write-port semantics match the existing single register: a write lands on the clock edge when the write enable is high.

Parameters:
- BITS, 4, data width of each register
- NREGS, 8, number of registers (power of two, at least 2)
- ABITS, $clog2(NREGS), address width (derived; do not override)
- ZERO_REG, 1, if 1 register 0 reads as 0 and writes to it are dropped

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset: synchronous, active-high (fixed)
- wenable  in  1  write strobe
- waddr  in  ABITS  write address
- wdata  in  BITS  write data
- raddr0  in  ABITS  read port 0 address
- rdata0  out  BITS  read port 0 data, registered
- raddr1  in  ABITS  read port 1 address
- rdata1  out  BITS  read port 1 data, registered
- dump_start  in  1  pulse to begin a full dump
- dump_busy  out  1  dump in progress
- dump_valid  out  1  dump_addr/dump_data are valid
- dump_ready  in  1  consumer accepts the current dump beat
- dump_addr  out  ABITS  index of the register being dumped
- dump_data  out  BITS  snapshot of that register

Behaviour:
- Reset (rst=1 at an edge):
  - all registers, rdata0, rdata1, dump_data and dump_addr go to 0
  - dump_busy and dump_valid go to 0; FSM goes to IDLE
  - rst has priority over every other input, including mid-dump: the dump aborts and no further beat is presented.
- Write:
  - on an edge with wenable=1, regs[waddr] <= wdata
  - with ZERO_REG=1 and waddr=0, the write is ignored.
- Read ports:
  - latency 1: rdataN after edge k = value at address raddrN sampled at edge k
  - write-first bypass: if wenable=1 and waddr==raddrN at the same edge, rdataN gets wdata; this does not apply to a dropped write to register 0
  - with ZERO_REG=1 and raddrN=0, rdataN = 0
  - both ports are independent and may use the same address.
- Dump FSM states: IDLE, LOAD, SEND.
  - IDLE: dump_busy=0, dump_valid=0. dump_start=1 leads to LOAD with idx=0 and dump_busy=1 from the next cycle.
  - LOAD (1 cycle): dump_data <= regs[idx], using the same bypass and zero rules as the read ports; dump_addr <= idx; next state is SEND.
  - SEND: dump_valid=1. dump_addr and dump_data hold stable until dump_valid&&dump_ready, even if regs[idx] is rewritten meanwhile.
  - On handshake: if idx==NREGS-1 go to IDLE (busy and valid drop the next cycle); otherwise idx++ and go to LOAD.
  - dump_start is ignored while dump_busy=1.
  - Throughput is 2 cycles per beat minimum; a full dump takes at least 2*NREGS cycles after start.
- Writes and reads are legal at all times during a dump and are unaffected by it.
- dump_ready held high in IDLE/LOAD has no effect.

Decomposition:
- Package regfile_pkg holds:
  - the dump FSM state enum (IDLE/LOAD/SEND)
  - a shared function computing read-with-bypass (addr, waddr, wenable, wdata, ZERO_REG)
- Storage plus read ports stay in regfile_rd.
- The dump FSM is a natural sub-module, regfile_dump_fsm. It takes a read-address output and a data input back from the bank, so the bypass function is reused.

Test Plan:
- Reset then read: rst=1 for 2 cycles, then raddr0=3, raddr1=5 -> rdata0=0, rdata1=0 after 1 cycle; dump_busy=0.
- Write then read: write 4'b1010 to reg 3; the next cycle raddr0=3 -> one edge later rdata0=4'b1010. With enable=0 and wdata=4'b1111, rdata0 stays 4'b1010.
- Bypass and zero: same cycle wenable=1, waddr=2, wdata=4'b0110, raddr0=raddr1=2 -> both rdata=4'b0110 after that edge. Write 4'b1111 to reg 0 -> reading reg 0 returns 0000.
- Full dump, ready always 1: regs[i]=i for i=1..7, pulse dump_start -> 8 beats with addrs 0..7 and data 0,1..7; each beat valid for exactly 1 cycle, 2 cycles apart; busy falls one cycle after beat 7.
- Backpressure and stability: dump_ready=0 for 5 cycles during the beat at addr 4, while reg 4 is rewritten to 4'b1100 in that window -> dump_data stays at the old value (4'b0100) until accepted. dump_start pulsed mid-dump is ignored (beat count still 8).
- Reset mid-dump: rst=1 while at addr 3 in SEND -> next cycle dump_valid=0, busy=0, all regs 0; a new dump_start restarts at addr 0.
